// File: rtl/gate_pkg.sv
// Shared mode encodings for the debounced gate reduction select.
package gate_pkg;
  localparam int MODE_W = 2;

  localparam logic [MODE_W-1:0] MODE_AND  = 2'd0;
  localparam logic [MODE_W-1:0] MODE_OR   = 2'd1;
  localparam logic [MODE_W-1:0] MODE_XOR  = 2'd2;
  localparam logic [MODE_W-1:0] MODE_NAND = 2'd3;
endpackage

// File: rtl/debounce_ch.sv
// One input channel: two-flop synchroniser followed by a persistence counter
// that only accepts a new level after DEBOUNCE consecutive mismatching clocks.
module debounce_ch #(
  parameter int DEBOUNCE = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);
  localparam int CNT_W = (DEBOUNCE < 2) ? 1 : $clog2(DEBOUNCE + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);

  logic             sync1_q, sync2_q;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      stable_d = sync2_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= din;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign dout = stable_q;
endmodule

// File: rtl/debounced_gate.sv
// N_IN debounced inputs reduced by a runtime-selected function into one
// registered output, plus a one-cycle pulse whenever that output toggles.
module debounced_gate
  import gate_pkg::*;
#(
  parameter int N_IN     = 2,
  parameter int DEBOUNCE = 50000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_IN-1:0]   in_bits,
  input  logic [MODE_W-1:0] mode,
  output logic [N_IN-1:0]   stable_q,
  output logic              out_0,
  output logic              out_changed
);
  logic out_q, out_d;
  logic changed_q, changed_d;

  for (genvar i = 0; i < N_IN; i++) begin : g_ch
    debounce_ch #(
      .DEBOUNCE(DEBOUNCE)
    ) u_ch (
      .clk (clk),
      .rst (rst),
      .din (in_bits[i]),
      .dout(stable_q[i])
    );
  end

  // Mode is used directly (not synchronised) so a new mode shows after one edge.
  always_comb begin
    out_d = 1'b0;
    case (mode)
      MODE_AND:  out_d = &stable_q;
      MODE_OR:   out_d = |stable_q;
      MODE_XOR:  out_d = ^stable_q;
      MODE_NAND: out_d = ~&stable_q;
      default:   out_d = 1'b0;
    endcase
    changed_d = (out_d != out_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q     <= 1'b0;
      changed_q <= 1'b0;
    end else begin
      out_q     <= out_d;
      changed_q <= changed_d;
    end
  end

  assign out_0       = out_q;
  assign out_changed = changed_q;
endmodule
